// File: rtl/user_edge_window_gen.sv
// Pixel-fetch front end for the edge-detect accelerator: reads the image from the
// user ROM one byte at a time and streams a 3x3 window for every interior pixel.
module user_edge_window_gen #(
  parameter int ImgWidth  = 16,
  parameter int ImgHeight = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rom_req_o,
  output logic [AddrWidth-1:0] rom_addr_o,
  input  logic [7:0]           rom_data_i,
  input  logic                 rom_valid_i,
  output logic                 win_valid_o,
  input  logic                 win_ready_i,
  output logic [71:0]          win_o,
  output logic [AddrWidth-1:0] win_x_o,
  output logic [AddrWidth-1:0] win_y_o
);

  localparam int IdxW = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
  localparam logic [AddrWidth-1:0] XLast = AddrWidth'(ImgWidth - 1);
  localparam logic [AddrWidth-1:0] YLast = AddrWidth'(ImgHeight - 1);
  localparam logic [AddrWidth-1:0] One   = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] Two   = AddrWidth'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state_reg;
  logic [AddrWidth-1:0] x_reg;
  logic [AddrWidth-1:0] y_reg;
  logic                 start_q_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 rom_req_reg;
  logic [AddrWidth-1:0] rom_addr_reg;
  logic                 win_valid_reg;
  logic [AddrWidth-1:0] win_x_reg;
  logic [AddrWidth-1:0] win_y_reg;

  // Row r of the window, column c in byte c; rows are y-2, y-1, y.
  logic [2:0][7:0]      win_reg [3];

  logic [7:0]           line1_mem [ImgWidth];
  logic [7:0]           line2_mem [ImgWidth];
  logic [7:0]           line1_rd_reg;
  logic [7:0]           line2_rd_reg;

  logic [IdxW-1:0]      col_idx;
  logic                 capture;
  logic [2:0][7:0]      new_col;

  assign col_idx = x_reg[IdxW-1:0];
  assign capture = (state_reg == S_WAIT) && rom_valid_i;
  assign new_col = {rom_data_i, line1_rd_reg, line2_rd_reg};

  // x is fixed from REQ onward, so the registered read is settled before any capture.
  always_ff @(posedge clk_i) begin
    line1_rd_reg <= line1_mem[col_idx];
    line2_rd_reg <= line2_mem[col_idx];
    if (capture) begin
      line1_mem[col_idx] <= rom_data_i;
      line2_mem[col_idx] <= line1_rd_reg;
    end
  end

  // Columns shift left by one per captured pixel; stale columns after a row wrap
  // are flushed before the first window of the new row (x >= 2).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          win_reg[gi] <= '0;
        end else if (capture) begin
          win_reg[gi] <= {new_col[gi], win_reg[gi][2], win_reg[gi][1]};
        end
      end
      assign win_o[24*gi +: 24] = win_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      start_q_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rom_req_reg   <= 1'b0;
      rom_addr_reg  <= '0;
      win_valid_reg <= 1'b0;
      win_x_reg     <= '0;
      win_y_reg     <= '0;
    end else begin
      start_q_reg <= start_i;
      done_reg    <= 1'b0;
      rom_req_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_i && !start_q_reg) begin
            x_reg        <= '0;
            y_reg        <= '0;
            rom_addr_reg <= '0;
            rom_req_reg  <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= S_REQ;
          end
        end
        S_REQ: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (rom_valid_i) begin
            if (x_reg >= Two && y_reg >= Two) begin
              win_valid_reg <= 1'b1;
              win_x_reg     <= x_reg - One;
              win_y_reg     <= y_reg - One;
              state_reg     <= S_EMIT;
            end else begin
              state_reg <= S_NEXT;
            end
          end
        end
        S_EMIT: begin
          if (win_ready_i) begin
            win_valid_reg <= 1'b0;
            state_reg     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (x_reg == XLast && y_reg == YLast) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            if (x_reg == XLast) begin
              x_reg <= '0;
              y_reg <= y_reg + One;
            end else begin
              x_reg <= x_reg + One;
            end
            // Raster order makes y*ImgWidth+x simply the previous address plus one.
            rom_addr_reg <= rom_addr_reg + One;
            rom_req_reg  <= 1'b1;
            state_reg    <= S_REQ;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg      <= 1'b0;
          win_valid_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign rom_req_o   = rom_req_reg;
  assign rom_addr_o  = rom_addr_reg;
  assign win_valid_o = win_valid_reg;
  assign win_x_o     = win_x_reg;
  assign win_y_o     = win_y_reg;

endmodule

// File: tb/tb_user_edge_window_gen.sv
// Bench for user_edge_window_gen: a 16x16 instance and a 4x4 instance driven by
// randomised ROM latency and consumer backpressure, checked against a window model.
`timescale 1ns/1ps
module tb_user_edge_window_gen;

  localparam int W   = 16;
  localparam int H   = 16;
  localparam int AW  = 8;
  localparam int NW  = (W - 2) * (H - 2);
  localparam int W2  = 4;
  localparam int H2  = 4;
  localparam int NW2 = (W2 - 2) * (H2 - 2);

  typedef struct packed {
    logic [71:0] w;
    logic [7:0]  x;
    logic [7:0]  y;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // 16x16 instance
  logic          start = 1'b0;
  logic          busy, done, rom_req, rom_valid, win_valid;
  logic          win_ready = 1'b0;
  logic [AW-1:0] rom_addr, win_x, win_y;
  logic [7:0]    rom_data;
  logic [71:0]   win;
  logic          resp_valid = 1'b0, spur_valid = 1'b0;
  logic [7:0]    resp_data = 8'h0, spur_data = 8'h0;
  assign rom_valid = resp_valid | spur_valid;
  assign rom_data  = spur_valid ? spur_data : resp_data;

  // 4x4 instance
  logic          b_start = 1'b0;
  logic          b_busy, b_done, b_rom_req, b_win_valid;
  logic          b_rom_valid = 1'b0, b_win_ready = 1'b0;
  logic [AW-1:0] b_rom_addr, b_win_x, b_win_y;
  logic [7:0]    b_rom_data = 8'h0;
  logic [71:0]   b_win;

  user_edge_window_gen #(.ImgWidth(W), .ImgHeight(H), .AddrWidth(AW)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rom_valid_i(rom_valid), .win_valid_o(win_valid), .win_ready_i(win_ready),
    .win_o(win), .win_x_o(win_x), .win_y_o(win_y)
  );

  user_edge_window_gen #(.ImgWidth(W2), .ImgHeight(H2), .AddrWidth(AW)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .rom_req_o(b_rom_req), .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
    .rom_valid_i(b_rom_valid), .win_valid_o(b_win_valid), .win_ready_i(b_win_ready),
    .win_o(b_win), .win_x_o(b_win_x), .win_y_o(b_win_y)
  );

  logic [7:0] img_a [256];
  logic [7:0] img_b [16];
  xfer_t      got_a [$];
  xfer_t      got_b [$];
  int n_checks = 0, n_fail = 0;
  int done_a = 0, done_b = 0, nreq_a = 0, nreq_b = 0;
  int req_viol_a = 0, req_viol_b = 0, stab_viol_a = 0;
  int delay_lo = 0, delay_hi = 0;
  bit outst_a = 0, outst_b = 0, prev_stall_a = 0, hold_a = 0, rand_a = 0;
  xfer_t prev_a;

  // Reference window: byte 3*r+c = pixel(yc-1+r, xc-1+c), raster order of centres.
  function automatic logic [71:0] model_a(int k);
    int xc = 1 + k % (W - 2);
    int yc = 1 + k / (W - 2);
    logic [71:0] r = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        r[8*(3*rr+cc) +: 8] = img_a[(yc - 1 + rr) * W + xc - 1 + cc];
    return r;
  endfunction

  function automatic logic [71:0] model_b(int k);
    int xc = 1 + k % (W2 - 2);
    int yc = 1 + k / (W2 - 2);
    logic [71:0] r = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        r[8*(3*rr+cc) +: 8] = img_b[(yc - 1 + rr) * W2 + xc - 1 + cc];
    return r;
  endfunction

  // ROM A: answers each request after 0..N extra WAIT cycles.
  initial begin
    logic [7:0] a;
    int d;
    forever begin
      @(posedge clk); #1;
      if (rom_req) begin
        a = rom_addr;
        d = int'($urandom_range(delay_hi, delay_lo));
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        resp_data  = img_a[a];
        resp_valid = 1'b1;
        @(posedge clk); #1;
        resp_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] a;
    int d;
    forever begin
      @(posedge clk); #1;
      if (b_rom_req) begin
        a = b_rom_addr;
        d = int'($urandom_range(5, 0));
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        b_rom_data  = img_b[a[3:0]];
        b_rom_valid = 1'b1;
        @(posedge clk); #1;
        b_rom_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      win_ready   = hold_a ? 1'b0 : (rand_a ? ($urandom_range(0, 3) != 0) : 1'b1);
      b_win_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitors sample mid-cycle: values seen here are what the next edge acts on.
  initial begin
    forever begin
      @(negedge clk);
      if (win_valid && win_ready) begin
        got_a.push_back({win, win_x, win_y});
        $display("[%0t] A window x=%0d y=%0d data=%h", $time, win_x, win_y, win);
      end
      if (done) done_a++;
      if (rom_req) begin
        nreq_a++;
        if (outst_a) req_viol_a++;
        outst_a = 1'b1;
      end
      if (resp_valid) outst_a = 1'b0;
      if (prev_stall_a && (!win_valid || {win, win_x, win_y} != prev_a)) stab_viol_a++;
      prev_stall_a = win_valid && !win_ready;
      prev_a = {win, win_x, win_y};
      if (b_win_valid && b_win_ready) begin
        got_b.push_back({b_win, b_win_x, b_win_y});
        $display("[%0t] B window x=%0d y=%0d data=%h", $time, b_win_x, b_win_y, b_win);
      end
      if (b_done) done_b++;
      if (b_rom_req) begin
        nreq_b++;
        if (outst_b) req_viol_b++;
        outst_b = 1'b1;
      end
      if (b_rom_valid) outst_b = 1'b0;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d windows", got_a.size());
    $fatal(1, "watchdog");
  end

  task automatic pulse_start_a();
    @(posedge clk); #1;
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int base, output bit ok);
    int n = 0;
    while (done_a == base && n < 20000) begin
      @(negedge clk);
      n++;
    end
    ok = (done_a != base);
  endtask

  task automatic test_reset();
    logic [161:0] obs_a, obs_b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs_a = {busy, done, rom_req, rom_addr, win_valid, win, win_x, win_y};
    obs_b = {b_busy, b_done, b_rom_req, b_rom_addr, b_win_valid, b_win, b_win_x, b_win_y};
    n_checks++;
    if (obs_a !== '0) begin n_fail++; $display("FAIL reset_a: got %h, want 0", obs_a); end
    n_checks++;
    if (obs_b !== '0) begin n_fail++; $display("FAIL reset_b: got %h, want 0", obs_b); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int base;
    bit ok;
    xfer_t exp;
    for (int a = 0; a < 256; a++) img_a[a] = 8'(a);
    delay_lo = 0; delay_hi = 2; hold_a = 0; rand_a = 0;
    got_a.delete();
    base = done_a;
    pulse_start_a();
    wait_done_a(base, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: done seen %0d, want 1", done_a - base); end
    n_checks++;
    if (done_a != base + 1) begin n_fail++; $display("FAIL full_done_count: got %0d, want 1", done_a - base); end
    n_checks++;
    if (got_a.size() != NW) begin n_fail++; $display("FAIL full_count: got %0d, want %0d", got_a.size(), NW); end
    if (got_a.size() > 0) begin
      n_checks++;
      if (got_a[0] !== {72'h222120121110020100, 8'd1, 8'd1})
        begin n_fail++; $display("FAIL full_first: got %h, want %h", got_a[0], {72'h222120121110020100, 8'd1, 8'd1}); end
      n_checks++;
      if (got_a[$].x !== 8'd14 || got_a[$].y !== 8'd14)
        begin n_fail++; $display("FAIL full_last: got (%0d,%0d), want (14,14)", got_a[$].x, got_a[$].y); end
    end
    for (int k = 0; k < got_a.size() && k < NW; k++) begin
      exp = {model_a(k), 8'(1 + k % (W - 2)), 8'(1 + k / (W - 2))};
      n_checks++;
      if (got_a[k] !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL full_win[%0d]: got %h, want %h", k, got_a[k], exp);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_small_frame();
    int base, n;
    xfer_t exp;
    for (int a = 0; a < 16; a++) img_b[a] = 8'($urandom);
    got_b.delete();
    base = done_b;
    n = 0;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (done_b == base && n < 5000) begin @(negedge clk); n++; end
    n_checks++;
    if (done_b != base + 1) begin n_fail++; $display("FAIL small_done: got %0d, want 1", done_b - base); end
    n_checks++;
    if (got_b.size() != NW2) begin n_fail++; $display("FAIL small_count: got %0d, want %0d", got_b.size(), NW2); end
    for (int k = 0; k < got_b.size() && k < NW2; k++) begin
      exp = {model_b(k), 8'(1 + k % (W2 - 2)), 8'(1 + k / (W2 - 2))};
      n_checks++;
      if (got_b[k] !== exp) begin n_fail++; $display("FAIL small_win[%0d]: got %h, want %h", k, got_b[k], exp); end
    end
    n_checks++;
    if (req_viol_b != 0) begin n_fail++; $display("FAIL small_outstanding: got %0d overlaps, want 0", req_viol_b); end
    n_checks++;
    if (nreq_b != W2 * H2) begin n_fail++; $display("FAIL small_req_count: got %0d, want %0d", nreq_b, W2 * H2); end
  endtask

  task automatic test_backpressure();
    int base, n, req0;
    bit ok;
    xfer_t exp, cap;
    for (int a = 0; a < 256; a++) img_a[a] = 8'($urandom);
    delay_lo = 0; delay_hi = 3; hold_a = 1; rand_a = 0;
    got_a.delete();
    base = done_a;
    pulse_start_a();
    n = 0;
    while (!win_valid && n < 2000) begin @(negedge clk); n++; end
    cap = {win, win_x, win_y};
    req0 = nreq_a;
    n_checks++;
    if (cap !== {model_a(0), 8'd1, 8'd1}) begin n_fail++; $display("FAIL bp_first: got %h, want %h", cap, {model_a(0), 8'd1, 8'd1}); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (!win_valid || {win, win_x, win_y} !== cap)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h, want v=1 %h", i, win_valid, {win, win_x, win_y}, cap); end
    end
    n_checks++;
    if (nreq_a != req0) begin n_fail++; $display("FAIL bp_no_req: got %0d requests, want 0", nreq_a - req0); end
    hold_a = 0; rand_a = 1;
    wait_done_a(base, ok);
    n_checks++;
    if (got_a.size() != NW) begin n_fail++; $display("FAIL bp_count: got %0d, want %0d", got_a.size(), NW); end
    for (int k = 0; k < got_a.size() && k < NW; k++) begin
      exp = {model_a(k), 8'(1 + k % (W - 2)), 8'(1 + k / (W - 2))};
      n_checks++;
      if (got_a[k] !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL bp_win[%0d]: got %h, want %h", k, got_a[k], exp);
      end
    end
    n_checks++;
    if (stab_viol_a != 0 || req_viol_a != 0)
      begin n_fail++; $display("FAIL bp_protocol: got %0d unstable, %0d overlaps, want 0", stab_viol_a, req_viol_a); end
    rand_a = 0;
  endtask

  task automatic test_restart_ignored();
    int base;
    bit ok;
    xfer_t exp;
    for (int a = 0; a < 256; a++) img_a[a] = 8'($urandom);
    delay_lo = 0; delay_hi = 1;
    got_a.delete();
    base = done_a;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (50) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1;
    wait_done_a(base, ok);
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_a != base + 1) begin n_fail++; $display("FAIL restart_done: got %0d, want 1", done_a - base); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_retrigger: busy %b, want 0", busy); end
    n_checks++;
    if (got_a.size() != NW) begin n_fail++; $display("FAIL restart_count: got %0d, want %0d", got_a.size(), NW); end
    for (int k = 0; k < got_a.size() && k < NW; k++) begin
      exp = {model_a(k), 8'(1 + k % (W - 2)), 8'(1 + k / (W - 2))};
      n_checks++;
      if (got_a[k] !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL restart_win[%0d]: got %h, want %h", k, got_a[k], exp);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int base, n;
    bit ok;
    xfer_t exp;
    logic [161:0] obs;
    for (int a = 0; a < 256; a++) img_a[a] = 8'($urandom);
    delay_lo = 4; delay_hi = 4;
    got_a.delete();
    base = done_a;
    pulse_start_a();
    n = 0;
    while (got_a.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    while (!rom_req && n < 3000) begin @(negedge clk); n++; end
    n_checks++;
    if (!rom_req || !busy) begin n_fail++; $display("FAIL mid_setup: req=%b busy=%b, want 1 1", rom_req, busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    obs = {busy, done, rom_req, rom_addr, win_valid, win, win_x, win_y};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h, want 0", obs); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, win_valid, rom_req} !== 3'b000)
        begin n_fail++; $display("FAIL mid_late_valid[%0d]: got %b, want 000", i, {busy, win_valid, rom_req}); end
    end
    n_checks++;
    if (done_a != base) begin n_fail++; $display("FAIL mid_no_done: got %0d, want 0", done_a - base); end
    delay_lo = 0; delay_hi = 3;
    got_a.delete();
    pulse_start_a();
    wait_done_a(base, ok);
    n_checks++;
    if (got_a.size() != NW) begin n_fail++; $display("FAIL mid_refetch_count: got %0d, want %0d", got_a.size(), NW); end
    for (int k = 0; k < got_a.size() && k < NW; k++) begin
      exp = {model_a(k), 8'(1 + k % (W - 2)), 8'(1 + k / (W - 2))};
      n_checks++;
      if (got_a[k] !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL mid_win[%0d]: got %h, want %h", k, got_a[k], exp);
      end
    end
  endtask

  task automatic test_spurious_valid();
    int base, n;
    bit ok;
    xfer_t exp, idle_obs;
    for (int a = 0; a < 256; a++) img_a[a] = 8'($urandom);
    delay_lo = 0; delay_hi = 2;
    idle_obs = {win, win_x, win_y};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      spur_valid = 1'b1;
      spur_data  = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if ({busy, win_valid, rom_req} !== 3'b000 || {win, win_x, win_y} !== idle_obs)
        begin n_fail++; $display("FAIL spur_idle[%0d]: got %b %h, want 000 %h", i, {busy, win_valid, rom_req}, {win, win_x, win_y}, idle_obs); end
    end
    @(posedge clk); #1;
    spur_valid = 1'b0;
    hold_a = 1;
    got_a.delete();
    base = done_a;
    pulse_start_a();
    n = 0;
    while (!win_valid && n < 2000) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      spur_valid = 1'b1;
      spur_data  = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (!win_valid || {win, win_x, win_y} !== {model_a(0), 8'd1, 8'd1})
        begin n_fail++; $display("FAIL spur_emit[%0d]: got v=%b %h, want v=1 %h", i, win_valid, {win, win_x, win_y}, {model_a(0), 8'd1, 8'd1}); end
    end
    @(posedge clk); #1;
    spur_valid = 1'b0;
    hold_a = 0;
    wait_done_a(base, ok);
    n_checks++;
    if (got_a.size() != NW) begin n_fail++; $display("FAIL spur_count: got %0d, want %0d", got_a.size(), NW); end
    for (int k = 0; k < got_a.size() && k < NW; k++) begin
      exp = {model_a(k), 8'(1 + k % (W - 2)), 8'(1 + k / (W - 2))};
      n_checks++;
      if (got_a[k] !== exp) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL spur_win[%0d]: got %h, want %h", k, got_a[k], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_small_frame();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_frame();
    test_spurious_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
